// File: rtl/debounce_edge_if.sv
// Signal bundle between the debounce/edge stage and its consumer.
// The master drives the synchronised level and the counter clear; the slave returns the debounced results.
interface debounce_edge_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sync_in;
  logic             cnt_clr;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] event_cnt;
  logic             cnt_sat;

  modport master (
    output sync_in,
    output cnt_clr,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  event_cnt,
    input  cnt_sat
  );

  modport slave (
    input  sync_in,
    input  cnt_clr,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output event_cnt,
    output cnt_sat
  );
endinterface

// File: rtl/debounce_edge.sv
// Debounces an already-synchronised level and emits rise/fall pulses.
// It also keeps a saturating count of debounced rises.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input logic             clk,
  input logic             rstn,
  debounce_edge_if.slave  bus
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  state_t             state;
  logic [STAB_W-1:0]  stab_cnt;
  logic               level_q;
  logic               rise_q;
  logic               fall_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;

  // Stability FSM: a new level is accepted only after STABLE_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_LOW;
      stab_cnt <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        ST_LOW: begin
          if (bus.sync_in) begin
            state    <= CHK_HIGH;
            stab_cnt <= STAB_W'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        CHK_HIGH: begin
          if (!bus.sync_in) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= ST_HIGH;
            stab_cnt <= '0;
            level_q  <= 1'b1;
            rise_q   <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        ST_HIGH: begin
          if (!bus.sync_in) begin
            state    <= CHK_LOW;
            stab_cnt <= STAB_W'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        CHK_LOW: begin
          if (bus.sync_in) begin
            state    <= ST_HIGH;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
            level_q  <= 1'b0;
            fall_q   <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        default: begin
          state    <= ST_LOW;
          stab_cnt <= '0;
          level_q  <= 1'b0;
        end
      endcase
    end
  end

  // Event counter follows rise_q by one cycle; a coincident clear is applied before the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.cnt_clr) begin
      cnt_q <= rise_q ? CNT_W'(1) : '0;
      sat_q <= 1'b0;
    end else if (rise_q) begin
      if (cnt_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.event_cnt  = cnt_q;
  assign bus.cnt_sat    = sat_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed and randomised checks of debounce_edge against a run-length reference model.
module tb_debounce_edge;

  localparam int unsigned S     = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rstn;

  debounce_edge_if #(.CNT_W(CNT_W)) bus ();

  debounce_edge #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: level changes once the input has disagreed with it for S samples in a row.
  int m_level, m_run, m_rise, m_fall, m_cnt, m_sat;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0; m_sat = 0;
  endtask

  task automatic model_edge(input int x, input int clr);
    if (clr != 0) begin
      m_cnt = (m_rise != 0) ? 1 : 0;
      m_sat = 0;
    end else if (m_rise != 0) begin
      if (m_cnt == CMAX) m_sat = 1;
      else               m_cnt = m_cnt + 1;
    end
    m_rise = 0;
    m_fall = 0;
    m_run  = (x != m_level) ? m_run + 1 : 0;
    if (m_run == S) begin
      m_level = x;
      m_rise  = x;
      m_fall  = 1 - x;
      m_run   = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, int'(bus.level_out),  m_level);
    check({tag, ".rise"},  int'(bus.rise_pulse), m_rise);
    check({tag, ".fall"},  int'(bus.fall_pulse), m_fall);
    check({tag, ".cnt"},   int'(bus.event_cnt),  m_cnt);
    check({tag, ".sat"},   int'(bus.cnt_sat),    m_sat);
  endtask

  task automatic step(input int x, input int clr, input string tag);
    bus.sync_in = x[0];
    bus.cnt_clr = clr[0];
    @(posedge clk);
    model_edge(x, clr);
    #1;
    check_all(tag);
  endtask

  // One debounced rise followed by a debounced fall.
  task automatic pulse_cycle(input string tag);
    for (int i = 0; i < S + 1; i++) step(1, 0, tag);
    for (int i = 0; i < S + 1; i++) step(0, 0, tag);
  endtask

  initial begin
    int n_rise;
    int n_fall;
    int lat;
    int lvl_before;
    model_reset();
    rstn        = 1'b0;
    bus.sync_in = 1'b0;
    bus.cnt_clr = 1'b0;
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Clean rise: held high for 6 samples.
    step(0, 0, "idle");
    step(0, 0, "idle");
    n_rise = 0; n_fall = 0; lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, "clean_rise");
      if (bus.rise_pulse === 1'b1) begin n_rise++; lat = i; end
      if (bus.fall_pulse === 1'b1) n_fall++;
    end
    check("clean_rise.latency", lat, S);
    check("clean_rise.count", n_rise, 1);
    check("clean_rise.nofall", n_fall, 0);
    check("clean_rise.event_cnt", int'(bus.event_cnt), 1);

    // Fall after S low samples; event_cnt untouched.
    n_fall = 0;
    for (int i = 0; i < S; i++) begin
      step(0, 0, "fall");
      if (bus.fall_pulse === 1'b1) n_fall++;
    end
    check("fall.count", n_fall, 1);
    check("fall.level", int'(bus.level_out), 0);
    check("fall.event_cnt", int'(bus.event_cnt), 1);

    // Glitch reject: 3 high, 1 low, 4 high.
    n_rise = 0; lat = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, "glitch_a");
      if (bus.rise_pulse === 1'b1) n_rise++;
    end
    step(0, 0, "glitch_gap");
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, "glitch_b");
      if (bus.rise_pulse === 1'b1) begin n_rise++; lat = i; end
    end
    step(1, 0, "glitch_hold");
    check("glitch.count", n_rise, 1);
    check("glitch.edge", lat, 4);
    check("glitch.event_cnt", int'(bus.event_cnt), 2);

    // Short low (3 samples) must not fall.
    n_fall = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, "short_low");
      if (bus.fall_pulse === 1'b1) n_fall++;
    end
    step(1, 0, "short_low_back");
    check("short_low.nofall", n_fall, 0);
    check("short_low.level", int'(bus.level_out), 1);

    // Toggling every cycle leaves the level unchanged.
    lvl_before = int'(bus.level_out);
    for (int i = 0; i < 20; i++) step(i % 2, 0, "toggle");
    check("toggle.level", int'(bus.level_out), lvl_before);

    // Saturation: 16 rises from a cleared counter.
    for (int i = 0; i < S + 1; i++) step(0, 0, "settle");
    step(0, 1, "sat_clr");
    for (int r = 1; r <= 16; r++) begin
      pulse_cycle("sat");
      if (r == 15) begin
        check("sat.cnt15", int'(bus.event_cnt), 15);
        check("sat.flag15", int'(bus.cnt_sat), 0);
      end
    end
    check("sat.cnt16", int'(bus.event_cnt), 15);
    check("sat.flag16", int'(bus.cnt_sat), 1);
    step(0, 1, "sat_clear");
    check("sat.clr_cnt", int'(bus.event_cnt), 0);
    check("sat.clr_flag", int'(bus.cnt_sat), 0);

    // Clear collision with event_cnt=7.
    for (int r = 0; r < 7; r++) pulse_cycle("coll_pre");
    check("coll.pre_cnt", int'(bus.event_cnt), 7);
    lat = 0;
    for (int i = 0; i < 3 * S && lat == 0; i++) begin
      step(1, 0, "coll_rise");
      if (bus.rise_pulse === 1'b1) lat = 1;
    end
    check("coll.rise_seen", lat, 1);
    step(1, 1, "coll_clr");
    check("coll.cnt", int'(bus.event_cnt), 1);
    check("coll.sat", int'(bus.cnt_sat), 0);
    for (int i = 0; i < S + 1; i++) step(0, 0, "coll_fall");

    // Randomised runs with occasional clears.
    for (int r = 0; r < 60; r++) begin
      int lvl;
      int len;
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++)
        step(lvl, ($urandom_range(0, 15) == 0) ? 1 : 0, "random");
    end

    // Asynchronous reset mid-check with sync_in high.
    step(0, 0, "pre_rst");
    for (int i = 0; i < S + 1; i++) step(0, 0, "pre_rst");
    step(1, 0, "pre_rst_chk");
    step(1, 0, "pre_rst_chk");
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 2 * S && lat == 0; i++) begin
      step(1, 0, "post_rst");
      if (bus.rise_pulse === 1'b1) lat = i;
    end
    check("post_rst.latency", lat, S);
    step(1, 0, "post_rst_cnt");
    check("post_rst.cnt", int'(bus.event_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
